dm_access_unit: RTL and testbench



---
 rtl/mem_pkg.sv | 37 +++
 rtl/dm_ram_be.sv | 38 +++
 rtl/dm_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_dm_access_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared MEM-stage codes: store/load op encodings, access FSM states and
// byte-lane helpers used by the data-memory access unit.
package mem_pkg;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_SW   = 2'b01;
  localparam logic [1:0] ST_SH   = 2'b10;
  localparam logic [1:0] ST_SB   = 2'b11;

  // Also decoded by the load-extension stage; keep in sync.
  localparam logic [2:0] LD_LW = 3'b000;
  localparam logic [2:0] LD_LH = 3'b001;
  localparam logic [2:0] LD_LB = 3'b010;

  typedef enum logic {
    StIdle,
    StBusy
  } dm_state_e;

  function automatic logic [3:0] byte_en(input logic [1:0] st_op, input logic [1:0] off);
    case (st_op)
      ST_SW:   byte_en = 4'b1111;
      ST_SH:   byte_en = off[1] ? 4'b1100 : 4'b0011;
      ST_SB:   byte_en = 4'b0001 << off;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] st_op, input logic [31:0] wdata);
    case (st_op)
      ST_SH:   lane_rep = {2{wdata[15:0]}};
      ST_SB:   lane_rep = {4{wdata[7:0]}};
      default: lane_rep = wdata;
    endcase
  endfunction

endpackage

// File: rtl/dm_ram_be.sv
// DEPTH x 32 synchronous RAM with per-byte write enables and a registered read
// port that holds its last value when no read is issued.
module dm_ram_be #(
  parameter int unsigned DEPTH  = 3072,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dm_access_unit.sv
// MEM-stage data-memory access unit: fault checking, byte-enabled stores,
// registered loads and a wait-state FSM that stalls the pipeline.
module dm_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH       = 3072,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  st_op,
  input  logic        ld_en,
  input  logic [2:0]  ld_op,
  output logic        stall,
  output logic        rd_valid,
  output logic [31:0] rdata,
  output logic [1:0]  a_out,
  output logic [2:0]  op_out,
  output logic        exc,
  output logic [31:0] exc_addr
);

  localparam int unsigned ADDR_W    = $clog2(DEPTH);
  localparam logic [32:0] ByteLimit = 33'(4 * DEPTH);
  localparam bit          HasWait   = (WAIT_CYCLES != 0);
  localparam logic [3:0]  CntInit   = HasWait ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dm_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic [ADDR_W-1:0] lat_idx_q, lat_idx_d;
  logic [1:0]        lat_off_q, lat_off_d;
  logic [31:0]       lat_wdata_q, lat_wdata_d;
  logic [1:0]        lat_st_op_q, lat_st_op_d;
  logic              lat_ld_q, lat_ld_d;
  logic [2:0]        lat_ld_op_q, lat_ld_op_d;

  logic        rd_valid_q, rd_valid_d;
  logic [1:0]  a_out_q, a_out_d;
  logic [2:0]  op_out_q, op_out_d;
  logic        exc_q, exc_d;
  logic [31:0] exc_addr_q, exc_addr_d;

  logic is_st, is_ld, is_word, is_half, misalign, oor, access, fault, legal;

  logic              exec;
  logic [ADDR_W-1:0] x_idx;
  logic [1:0]        x_off;
  logic [31:0]       x_wdata;
  logic [1:0]        x_st_op;
  logic              x_ld;
  logic [2:0]        x_ld_op;

  logic [3:0]  ram_we;
  logic        ram_re;
  logic [31:0] ram_wdata;

  // Request decode; a store always wins over ld_en.
  always_comb begin
    is_st    = (st_op != ST_NONE);
    is_ld    = !is_st && ld_en;
    is_word  = is_st ? (st_op == ST_SW) : (ld_op == LD_LW);
    is_half  = is_st ? (st_op == ST_SH) : (ld_op == LD_LH);
    misalign = (is_word && (addr[1:0] != 2'b00)) || (is_half && addr[0]);
    oor      = ({1'b0, addr} >= ByteLimit);
    access   = req && (is_st || is_ld);
    fault    = access && (misalign || oor);
    legal    = access && !fault;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_idx_d   = lat_idx_q;
    lat_off_d   = lat_off_q;
    lat_wdata_d = lat_wdata_q;
    lat_st_op_d = lat_st_op_q;
    lat_ld_d    = lat_ld_q;
    lat_ld_op_d = lat_ld_op_q;
    stall       = 1'b0;
    exec        = 1'b0;
    x_idx       = addr[ADDR_W+1:2];
    x_off       = addr[1:0];
    x_wdata     = wdata;
    x_st_op     = st_op;
    x_ld        = is_ld;
    x_ld_op     = ld_op;
    case (state_q)
      StIdle: begin
        if (legal) begin
          if (HasWait) begin
            stall       = 1'b1;
            state_d     = StBusy;
            cnt_d       = CntInit;
            lat_idx_d   = addr[ADDR_W+1:2];
            lat_off_d   = addr[1:0];
            lat_wdata_d = wdata;
            lat_st_op_d = st_op;
            lat_ld_d    = is_ld;
            lat_ld_op_d = ld_op;
          end else begin
            exec = 1'b1;
          end
        end
      end
      StBusy: begin
        x_idx   = lat_idx_q;
        x_off   = lat_off_q;
        x_wdata = lat_wdata_q;
        x_st_op = lat_st_op_q;
        x_ld    = lat_ld_q;
        x_ld_op = lat_ld_op_q;
        if (cnt_q != 4'd0) begin
          stall = 1'b1;
          cnt_d = cnt_q - 4'd1;
        end else begin
          exec    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset on the executing edge drops the access entirely.
  always_comb begin
    ram_we     = (exec && !reset) ? byte_en(x_st_op, x_off) : 4'b0000;
    ram_re     = exec && x_ld && !reset;
    ram_wdata  = lane_rep(x_st_op, x_wdata);
    rd_valid_d = ram_re;
    a_out_d    = ram_re ? x_off : a_out_q;
    op_out_d   = ram_re ? x_ld_op : op_out_q;
    exc_d      = (state_q == StIdle) && fault;
    exc_addr_d = exc_d ? addr : exc_addr_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      lat_idx_q   <= '0;
      lat_off_q   <= 2'b00;
      lat_wdata_q <= 32'h0;
      lat_st_op_q <= ST_NONE;
      lat_ld_q    <= 1'b0;
      lat_ld_op_q <= LD_LW;
      rd_valid_q  <= 1'b0;
      a_out_q     <= 2'b00;
      op_out_q    <= 3'b000;
      exc_q       <= 1'b0;
      exc_addr_q  <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_idx_q   <= lat_idx_d;
      lat_off_q   <= lat_off_d;
      lat_wdata_q <= lat_wdata_d;
      lat_st_op_q <= lat_st_op_d;
      lat_ld_q    <= lat_ld_d;
      lat_ld_op_q <= lat_ld_op_d;
      rd_valid_q  <= rd_valid_d;
      a_out_q     <= a_out_d;
      op_out_q    <= op_out_d;
      exc_q       <= exc_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  dm_ram_be #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (x_idx),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

  assign rd_valid = rd_valid_q;
  assign a_out    = a_out_q;
  assign op_out   = op_out_q;
  assign exc      = exc_q;
  assign exc_addr = exc_addr_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Bench for dm_access_unit: two instances (no wait states, two wait states)
// driven by directed and random accesses against a byte-array memory model.
module tb_dm_access_unit;

  localparam int Depth = 3072;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_s  [2];
  logic        req_s    [2];
  logic [31:0] addr_s   [2];
  logic [31:0] wdata_s  [2];
  logic [1:0]  st_s     [2];
  logic        ld_en_s  [2];
  logic [2:0]  ldop_s   [2];
  logic        stall_o  [2];
  logic        rdv_o    [2];
  logic [31:0] rdata_o  [2];
  logic [1:0]  a_o      [2];
  logic [2:0]  op_o     [2];
  logic        exc_o    [2];
  logic [31:0] excadr_o [2];

  dm_access_unit #(.DEPTH(Depth), .WAIT_CYCLES(0)) u_dm0 (
    .clk(clk), .reset(reset_s[0]), .req(req_s[0]), .addr(addr_s[0]), .wdata(wdata_s[0]),
    .st_op(st_s[0]), .ld_en(ld_en_s[0]), .ld_op(ldop_s[0]), .stall(stall_o[0]),
    .rd_valid(rdv_o[0]), .rdata(rdata_o[0]), .a_out(a_o[0]), .op_out(op_o[0]),
    .exc(exc_o[0]), .exc_addr(excadr_o[0])
  );

  dm_access_unit #(.DEPTH(Depth), .WAIT_CYCLES(2)) u_dm1 (
    .clk(clk), .reset(reset_s[1]), .req(req_s[1]), .addr(addr_s[1]), .wdata(wdata_s[1]),
    .st_op(st_s[1]), .ld_en(ld_en_s[1]), .ld_op(ldop_s[1]), .stall(stall_o[1]),
    .rd_valid(rdv_o[1]), .rdata(rdata_o[1]), .a_out(a_o[1]), .op_out(op_o[1]),
    .exc(exc_o[1]), .exc_addr(excadr_o[1])
  );

  int          waits [2] = '{0, 2};
  logic [7:0]  mb [2][4*Depth];
  logic [31:0] exp_rdata [2];
  logic [1:0]  exp_a [2];
  logic [2:0]  exp_op [2];
  logic [31:0] exp_excadr [2];
  int          errors = 0;
  int          checks = 0;
  int          cur_d = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d: got %h want %h", tag, cur_d, obs, exp_v);
    end
  endtask

  task automatic drive(input int d, input logic r, input logic [31:0] a, input logic [31:0] w,
                       input logic [1:0] st, input logic le, input logic [2:0] lo);
    req_s[d] = r; addr_s[d] = a; wdata_s[d] = w;
    st_s[d] = st; ld_en_s[d] = le; ldop_s[d] = lo;
  endtask

  task automatic idle_check(input int d);
    @(posedge clk); #1;
    drive(d, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 3'b000);
    #1;
    chk("idle_rdv", 32'(rdv_o[d]), 32'h0);
    chk("idle_exc", 32'(exc_o[d]), 32'h0);
    chk("idle_stall", 32'(stall_o[d]), 32'h0);
    chk("hold_rdata", rdata_o[d], exp_rdata[d]);
    chk("hold_a", 32'(a_o[d]), 32'(exp_a[d]));
    chk("hold_op", 32'(op_o[d]), 32'(exp_op[d]));
    chk("hold_excadr", excadr_o[d], exp_excadr[d]);
  endtask

  task automatic access(input int d, input logic [31:0] a, input logic [31:0] w,
                        input logic [1:0] st, input logic le, input logic [2:0] lo);
    bit is_st, is_ld, flt;
    int sz, wt, base;
    cur_d = d;
    is_st = (st != 2'b00);
    is_ld = !is_st && le;
    if (is_st) sz = (st == 2'b01) ? 4 : (st == 2'b10) ? 2 : 1;
    else       sz = (lo == 3'b000) ? 4 : (lo == 3'b001) ? 2 : 1;
    flt = (is_st || is_ld) && (((a % 32'(sz)) != 0) || (a >= 32'(4 * Depth)));
    @(posedge clk); #1;
    drive(d, 1'b1, a, w, st, le, lo);
    #1;
    if (flt) begin
      chk("fault_stall", 32'(stall_o[d]), 32'h0);
      @(posedge clk); #1;
      drive(d, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 3'b000);
      #1;
      exp_excadr[d] = a;
      chk("exc_pulse", 32'(exc_o[d]), 32'h1);
      chk("exc_addr", excadr_o[d], a);
      chk("fault_rdv", 32'(rdv_o[d]), 32'h0);
    end else begin
      wt = (is_st || is_ld) ? waits[d] : 0;
      chk("stall_c0", 32'(stall_o[d]), 32'(wt > 0));
      for (int i = 1; i <= wt; i++) begin
        @(posedge clk); #1;
        drive(d, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom),
              3'($urandom_range(0, 2)));
        #1;
        chk("stall_busy", 32'(stall_o[d]), 32'(i < wt));
      end
      @(posedge clk); #1;
      drive(d, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 3'b000);
      if (is_st) begin
        for (int k = 0; k < sz; k++) mb[d][int'(a) + k] = w[8*k +: 8];
      end
      #1;
      chk("done_exc", 32'(exc_o[d]), 32'h0);
      chk("done_rdv", 32'(rdv_o[d]), 32'(is_ld));
      if (is_ld) begin
        base = int'(a) - int'(a % 4);
        exp_rdata[d] = {mb[d][base+3], mb[d][base+2], mb[d][base+1], mb[d][base]};
        exp_a[d] = a[1:0];
        exp_op[d] = lo;
        chk("ld_rdata", rdata_o[d], exp_rdata[d]);
        chk("ld_a_out", 32'(a_o[d]), 32'(exp_a[d]));
        chk("ld_op_out", 32'(op_o[d]), 32'(exp_op[d]));
      end
    end
    idle_check(d);
  endtask

  task automatic reset_mid_busy(input int d, input logic [31:0] a, input logic [31:0] w);
    cur_d = d;
    @(posedge clk); #1;
    drive(d, 1'b1, a, w, 2'b01, 1'b0, 3'b000);
    #1;
    chk("rst_stall_c0", 32'(stall_o[d]), 32'h1);
    @(posedge clk); #1;
    drive(d, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 3'b000);
    reset_s[d] = 1'b1;
    @(posedge clk); #1;
    reset_s[d] = 1'b0;
    #1;
    exp_rdata[d] = 32'h0; exp_a[d] = 2'b00; exp_op[d] = 3'b000; exp_excadr[d] = 32'h0;
    chk("rst_stall", 32'(stall_o[d]), 32'h0);
    chk("rst_rdata", rdata_o[d], 32'h0);
    idle_check(d);
  endtask

  task automatic random_run(input int d, input int n);
    logic [31:0] a;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'(4 * Depth) + 32'($urandom_range(0, 7));
      else if (r == 1) a = $urandom;
      else             a = 32'($urandom_range(0, 255));
      access(d, a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 3'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      reset_s[d] = 1'b1;
      drive(d, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0, 3'b000);
      exp_rdata[d] = 32'h0; exp_a[d] = 2'b00; exp_op[d] = 3'b000; exp_excadr[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    reset_s[0] = 1'b0;
    reset_s[1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      cur_d = d;
      chk("rst_stall", 32'(stall_o[d]), 32'h0);
      chk("rst_rdv", 32'(rdv_o[d]), 32'h0);
      chk("rst_exc", 32'(exc_o[d]), 32'h0);
      chk("rst_rdata", rdata_o[d], 32'h0);
      chk("rst_a", 32'(a_o[d]), 32'h0);
      chk("rst_op", 32'(op_o[d]), 32'h0);
      chk("rst_excadr", excadr_o[d], 32'h0);
    end

    // Known-zero working region for both instances.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) access(d, 32'(4 * i), 32'h0, 2'b01, 1'b0, 3'b000);
    end

    access(0, 32'h10, 32'hDEADBEEF, 2'b01, 1'b1, 3'b000);
    access(0, 32'h10, 32'h0, 2'b00, 1'b1, 3'b000);
    access(0, 32'h13, 32'h000000AA, 2'b11, 1'b0, 3'b000);
    access(0, 32'h13, 32'h0, 2'b00, 1'b1, 3'b010);
    access(0, 32'h22, 32'h00001234, 2'b10, 1'b0, 3'b000);
    access(0, 32'h22, 32'h0, 2'b00, 1'b1, 3'b001);
    access(0, 32'h06, 32'h0, 2'b00, 1'b1, 3'b000);
    access(0, 32'(4 * Depth), 32'h0, 2'b00, 1'b1, 3'b010);
    access(0, 32'h04, 32'h0, 2'b00, 1'b1, 3'b000);
    access(0, 32'h10, 32'h0, 2'b00, 1'b1, 3'b000);

    access(1, 32'h30, 32'hCAFEF00D, 2'b01, 1'b0, 3'b000);
    access(1, 32'h30, 32'h0, 2'b00, 1'b1, 3'b000);
    access(1, 32'h31, 32'h0, 2'b00, 1'b1, 3'b010);
    reset_mid_busy(1, 32'h30, 32'h11223344);
    access(1, 32'h30, 32'h0, 2'b00, 1'b1, 3'b000);
    access(1, 32'h2A, 32'h0, 2'b10, 1'b0, 3'b000);

    random_run(0, 200);
    random_run(1, 150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
